logic_unit_pipe: RTL and testbench
==================================

Name: logic_unit_pipe

Overview:
- Parametrised, pipelined successor to the fixed 64-bit XOR block.
- Performs one of eight bitwise operations on two WIDTH-bit operands and returns the result through a configurable-depth pipeline.
- Uses valid/ready handshakes on both sides, with per-stage bubble collapsing and backpressure.
- Sits in the integer/FP-bitwise execution path of the RV64F datapath. It also serves sign-injection helpers (FSGNJ/FSGNJN/FSGNJX operand masking).

Parameters:
- WIDTH, 64, operand/result width in bits (≥1).
- STAGES, 2, pipeline depth; minimum input-to-output latency in cycles (≥1).
- TAG_W, 5, width of sideband tag carried alongside each operation (≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation present on inputs.
- in_ready  output  1  pipeline can accept an operation this cycle.
- in_op  input  3  operation select.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  sideband tag (e.g. destination register).
- out_valid  output  1  result present on outputs.
- out_ready  input  1  consumer accepts result this cycle.
- out_s  output  WIDTH  result.
- out_zero  output  1  1 when out_s == 0.
- out_tag  output  TAG_W  tag of the operation producing out_s.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values, while rst_n = 0: all stage valid bits = 0, all stage data/tag registers = 0. Consequently out_valid = 0, out_s = 0, out_zero = 1, out_tag = 0.
- in_ready may be 1 during reset because it is combinational from the cleared valids; no transfer is captured until rst_n deasserts.
- Op encoding (in_op):
  - 000 AND = a&b
  - 001 OR = a|b
  - 010 XOR = a^b
  - 011 XNOR = ~(a^b)
  - 100 ANDN = a&~b
  - 101 ORN = a|~b
  - 110 PASSA = a
  - 111 NOTA = ~a
- Result is computed combinationally from in_* and captured into stage 0. Stages 1..STAGES-1 only move data. out_s/out_tag/out_zero come directly from registers of stage STAGES-1. out_zero is computed at capture time and registered alongside the result.
- Stage i holds v[i], s[i], z[i], tag[i].
  - adv[STAGES-1] = !v[STAGES-1] | out_ready.
  - adv[i] = !v[i] | adv[i+1].
  - in_ready = adv[0]. Purely combinational; no register on the ready path.
- On a clock edge where adv[i] = 1, stage i loads from its predecessor (stage 0 loads from the inputs), including the predecessor's valid bit. Stage i holds when adv[i] = 0.
- Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
- Latency is exactly STAGES cycles when the pipeline is unstalled. Throughput is 1 op/cycle with out_ready held high.
- Bubbles collapse: an empty stage accepts data even when the downstream stage is stalled. With out_ready = 0 the pipeline absorbs up to STAGES ops; in_ready then drops to 0.
- Full pipeline with out_ready = 1 and in_valid = 1 on the same edge: the output retires and the input is accepted on that same edge, with no lost cycle.
- Operations leave in acceptance order; no reordering and no duplication.
- in_op/in_a/in_b/in_tag are don't-care when in_valid = 0; they are never captured into a valid stage.
- Output stability: while out_valid = 1 and out_ready = 0, out_s, out_zero and out_tag must be held stable.
- Reset mid-operation: all in-flight ops are discarded immediately (asynchronously); there is no partial-result output after rst_n rises.
- STAGES = 1: a single register stage; in_ready = !v[0] | out_ready.

Test Plan:
- Op sweep, WIDTH=64, STAGES=2, out_ready=1: a=64'hF0F0_F0F0_0000_FFFF, b=64'hFF00_FF00_FFFF_0000, ops 0..7 back to back.
  - Results appear cycles 2..9: AND=F000_F000_0000_0000, XOR=0FF0_0FF0_FFFF_FFFF, NOTA=0F0F_0F0F_FFFF_0000, etc.
  - Check: in_ready stays 1; tags are in order.
- Zero flag: XOR with a = b = 64'hDEAD_BEEF_0123_4567 -> out_s=0, out_zero=1. Then NOTA with a=all-ones -> out_zero=1. Then OR with 0,1 -> out_zero=0.
- Backpressure: out_ready=0, issue 5 ops with tags 1..5, STAGES=2.
  - Ops with tags 1 and 2 are accepted; in_ready=0 from the 3rd cycle.
  - out_s is held stable.
  - Raise out_ready -> tags 1..5 exit in order with no loss or duplication.
- Bubble collapse: send op tag 7, idle 1 cycle, op tag 8, with out_ready=0.
  - Both ops end up resident; in_ready=0 only after both are captured.
  - Then pulse out_ready 1 cycle -> only tag 7 retires.
- Reset mid-flight: 2 ops in flight, drop rst_n between clock edges -> out_valid=0 and out_s=0 immediately. After release, no stale result appears within 5 cycles.
- Random regression, WIDTH ∈ {32, 64, 7}, STAGES ∈ {1, 3}: 1000 random ops with random in_valid/out_ready. A scoreboard model compares every retired (s, zero, tag); the bench reports the error count, which must be 0.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: eight-way bitwise logic unit behind an elastic valid/ready
// pipeline of STAGES registers with per-stage bubble collapsing.
module logic_unit_pipe #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_XNOR  = 3'b011,
    OP_ANDN  = 3'b100,
    OP_ORN   = 3'b101,
    OP_PASSA = 3'b110,
    OP_NOTA  = 3'b111
  } op_e;

  logic [WIDTH-1:0]  result;
  logic              result_zero;

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] z;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  s   [STAGES];
  logic [TAG_W-1:0]  tag [STAGES];

  always_comb begin
    result = '0;
    case (op_e'(in_op))
      OP_AND:   result = in_a & in_b;
      OP_OR:    result = in_a | in_b;
      OP_XOR:   result = in_a ^ in_b;
      OP_XNOR:  result = ~(in_a ^ in_b);
      OP_ANDN:  result = in_a & ~in_b;
      OP_ORN:   result = in_a | ~in_b;
      OP_PASSA: result = in_a;
      OP_NOTA:  result = ~in_a;
      default:  result = '0;
    endcase
    result_zero = (result == '0);
  end

  // A stage may load when it is empty or when everything downstream of it can
  // move; accumulating the "room" term keeps this free of self-referencing loops.
  always_comb begin
    logic room;
    adv  = '0;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      room   = room | ~v[i];
      adv[i] = room;
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      z <= '1;
      for (int i = 0; i < STAGES; i++) begin
        s[i]   <= '0;
        tag[i] <= '0;
      end
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          s[0]   <= result;
          z[0]   <= result_zero;
          tag[0] <= in_tag;
        end
      end
      // Payload only moves with a valid predecessor, so bubbles never disturb data.
      for (int i = 1; i < STAGES; i++) begin
        if (adv[i]) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            s[i]   <= s[i-1];
            z[i]   <= z[i-1];
            tag[i] <= tag[i-1];
          end
        end
      end
    end
  end

  assign out_valid = v[STAGES-1];
  assign out_s     = s[STAGES-1];
  assign out_zero  = z[STAGES-1];
  assign out_tag   = tag[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed tests on a 64-bit/2-stage
// instance plus a random scoreboard regression on three other configurations.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [63:0] s;
    logic        z;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Directed instance (64-bit, 2 stages)
  logic        d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_zero;
  logic [2:0]  d_in_op;
  logic [63:0] d_in_a, d_in_b, d_out_s;
  logic [4:0]  d_in_tag, d_out_tag;

  logic_unit_pipe #(.WIDTH(64), .STAGES(2), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_op(d_in_op),
    .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_s(d_out_s),
    .out_zero(d_out_zero), .out_tag(d_out_tag)
  );

  // Random-regression instances share one stimulus stream
  logic        r_in_valid, r_out_ready;
  logic [2:0]  r_in_op;
  logic [63:0] r_in_a, r_in_b;
  logic [4:0]  r_in_tag;
  logic [2:0]  r_in_ready, r_out_valid, r_out_zero;
  logic [4:0]  r_out_tag [3];
  logic [31:0] r0_s;
  logic [63:0] r1_s;
  logic [6:0]  r2_s;
  logic [63:0] r_s [3];
  int          r_w [3] = '{32, 64, 7};
  int          r_acc [3] = '{0, 0, 0};

  assign r_s[0] = {32'd0, r0_s};
  assign r_s[1] = r1_s;
  assign r_s[2] = {57'd0, r2_s};

  logic_unit_pipe #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut_r0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(r_in_valid), .in_ready(r_in_ready[0]), .in_op(r_in_op),
    .in_a(r_in_a[31:0]), .in_b(r_in_b[31:0]), .in_tag(r_in_tag),
    .out_valid(r_out_valid[0]), .out_ready(r_out_ready), .out_s(r0_s),
    .out_zero(r_out_zero[0]), .out_tag(r_out_tag[0])
  );

  logic_unit_pipe #(.WIDTH(64), .STAGES(3), .TAG_W(5)) dut_r1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(r_in_valid), .in_ready(r_in_ready[1]), .in_op(r_in_op),
    .in_a(r_in_a), .in_b(r_in_b), .in_tag(r_in_tag),
    .out_valid(r_out_valid[1]), .out_ready(r_out_ready), .out_s(r1_s),
    .out_zero(r_out_zero[1]), .out_tag(r_out_tag[1])
  );

  logic_unit_pipe #(.WIDTH(7), .STAGES(3), .TAG_W(5)) dut_r2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(r_in_valid), .in_ready(r_in_ready[2]), .in_op(r_in_op),
    .in_a(r_in_a[6:0]), .in_b(r_in_b[6:0]), .in_tag(r_in_tag),
    .out_valid(r_out_valid[2]), .out_ready(r_out_ready), .out_s(r2_s),
    .out_zero(r_out_zero[2]), .out_tag(r_out_tag[2])
  );

  exp_t d_q [$];
  exp_t r_q [3][$];

  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [4:0] t, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~(a ^ b);
      3'd4: r = a & ~b;
      3'd5: r = a | ~b;
      3'd6: r = a;
      default: r = ~a;
    endcase
    m = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    r = r & m;
    model.s   = r;
    model.z   = (r == 64'd0);
    model.tag = t;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", name, observed, expected);
    end
  endtask

  // Drives the directed instance just after a falling edge and returns shortly
  // before the next rising edge, where the caller samples pre-edge state.
  task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [63:0] a,
                               input logic [63:0] b, input logic [4:0] t, input logic ordy);
    @(negedge clk);
    d_in_valid  = v;
    d_in_op     = op;
    d_in_a      = a;
    d_in_b      = b;
    d_in_tag    = t;
    d_out_ready = ordy;
    #4;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin : monitor
    exp_t e;
    #4;
    if (!rst_n) begin
      d_q.delete();
      for (int k = 0; k < 3; k++) r_q[k].delete();
    end else begin
      if (d_in_valid && d_in_ready)
        d_q.push_back(model(d_in_op, d_in_a, d_in_b, d_in_tag, 64));
      if (d_out_valid && d_out_ready) begin
        checkOutput("d_q_avail", 64'(d_q.size() != 0), 64'd1);
        if (d_q.size() != 0) begin
          e = d_q.pop_front();
          checkOutput("d_s", d_out_s, e.s);
          checkOutput("d_zero", 64'(d_out_zero), 64'(e.z));
          checkOutput("d_tag", 64'(d_out_tag), 64'(e.tag));
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (r_in_valid && r_in_ready[k]) begin
          r_q[k].push_back(model(r_in_op, r_in_a, r_in_b, r_in_tag, r_w[k]));
          r_acc[k]++;
        end
        if (r_out_valid[k] && r_out_ready) begin
          checkOutput($sformatf("r%0d_q_avail", k), 64'(r_q[k].size() != 0), 64'd1);
          if (r_q[k].size() != 0) begin
            e = r_q[k].pop_front();
            checkOutput($sformatf("r%0d_s", k), r_s[k], e.s);
            checkOutput($sformatf("r%0d_zero", k), 64'(r_out_zero[k]), 64'(e.z));
            checkOutput($sformatf("r%0d_tag", k), 64'(r_out_tag[k]), 64'(e.tag));
          end
        end
      end
    end
  end

  localparam logic [63:0] SWA = 64'hF0F0_F0F0_0000_FFFF;
  localparam logic [63:0] SWB = 64'hFF00_FF00_FFFF_0000;

  initial begin
    int   idx;
    exp_t bp_first;
    logic [63:0] ta, tb;

    rst_n = 1'b0;
    d_in_valid = 1'b0; d_in_op = 3'd0; d_in_a = '0; d_in_b = '0; d_in_tag = '0;
    d_out_ready = 1'b0;
    r_in_valid = 1'b0; r_in_op = 3'd0; r_in_a = '0; r_in_b = '0; r_in_tag = '0;
    r_out_ready = 1'b0;

    repeat (2) @(negedge clk);
    #4;
    checkOutput("rst_out_valid", 64'(d_out_valid), 64'd0);
    checkOutput("rst_out_s", d_out_s, 64'd0);
    checkOutput("rst_out_zero", 64'(d_out_zero), 64'd1);
    checkOutput("rst_out_tag", 64'(d_out_tag), 64'd0);
    checkOutput("rst_r1_valid", 64'(r_out_valid[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] op sweep");
    for (int k = 0; k < 10; k++) begin
      if (k < 8) applyStimulus(1'b1, 3'(k), SWA, SWB, 5'(k), 1'b1);
      else       applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
      checkOutput("sweep_in_ready", 64'(d_in_ready), 64'd1);
      if (k >= 2) begin
        checkOutput("sweep_out_valid", 64'(d_out_valid), 64'd1);
        checkOutput("sweep_out_tag", 64'(d_out_tag), 64'(k - 2));
      end
      if (k == 2) checkOutput("sweep_and", d_out_s, 64'hF000_F000_0000_0000);
      if (k == 4) checkOutput("sweep_xor", d_out_s, 64'h0FF0_0FF0_FFFF_FFFF);
      if (k == 9) checkOutput("sweep_nota", d_out_s, 64'h0F0F_0F0F_FFFF_0000);
    end

    $display("[TB] zero flag");
    applyStimulus(1'b1, 3'd2, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 5'd10, 1'b1);
    applyStimulus(1'b1, 3'd7, {64{1'b1}}, 64'd0, 5'd11, 1'b1);
    applyStimulus(1'b1, 3'd1, 64'd0, 64'd1, 5'd12, 1'b1);
    checkOutput("zero_xor_tag", 64'(d_out_tag), 64'd10);
    checkOutput("zero_xor_s", d_out_s, 64'd0);
    checkOutput("zero_xor_z", 64'(d_out_zero), 64'd1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
    checkOutput("zero_nota_tag", 64'(d_out_tag), 64'd11);
    checkOutput("zero_nota_z", 64'(d_out_zero), 64'd1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
    checkOutput("zero_or_tag", 64'(d_out_tag), 64'd12);
    checkOutput("zero_or_s", d_out_s, 64'd1);
    checkOutput("zero_or_z", 64'(d_out_zero), 64'd0);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);

    $display("[TB] backpressure");
    idx = 1;
    bp_first = model(3'd1, 64'h0123_4567_89AB_CDEF ^ {8{8'd1}}, 64'h0F0F_0000_FFFF_1234, 5'd1, 64);
    for (int st = 0; st < 20; st++) begin
      if (idx <= 5)
        applyStimulus(1'b1, 3'(idx), 64'h0123_4567_89AB_CDEF ^ {8{8'(idx)}},
                      64'h0F0F_0000_FFFF_1234, 5'(idx), st >= 6);
      else
        applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, st >= 6);
      if (st < 2) checkOutput("bp_in_ready_open", 64'(d_in_ready), 64'd1);
      if (st >= 2 && st < 6) begin
        checkOutput("bp_in_ready_full", 64'(d_in_ready), 64'd0);
        checkOutput("bp_hold_valid", 64'(d_out_valid), 64'd1);
        checkOutput("bp_hold_tag", 64'(d_out_tag), 64'd1);
        checkOutput("bp_hold_s", d_out_s, bp_first.s);
      end
      if (d_in_ready && idx <= 5) idx++;
    end
    checkOutput("bp_all_accepted", 64'(idx), 64'd6);
    checkOutput("bp_drained", 64'(d_q.size()), 64'd0);
    checkOutput("bp_no_dup", 64'(d_out_valid), 64'd0);

    $display("[TB] bubble collapse");
    applyStimulus(1'b1, 3'd1, 64'h1111, 64'h2222, 5'd7, 1'b0);
    checkOutput("bub_in_ready0", 64'(d_in_ready), 64'd1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b0);
    checkOutput("bub_in_ready1", 64'(d_in_ready), 64'd1);
    applyStimulus(1'b1, 3'd2, 64'h3333, 64'h4444, 5'd8, 1'b0);
    checkOutput("bub_in_ready2", 64'(d_in_ready), 64'd1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b0);
    checkOutput("bub_in_ready_full", 64'(d_in_ready), 64'd0);
    checkOutput("bub_head_tag", 64'(d_out_tag), 64'd7);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
    checkOutput("bub_pulse_tag", 64'(d_out_tag), 64'd7);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b0);
    checkOutput("bub_next_valid", 64'(d_out_valid), 64'd1);
    checkOutput("bub_next_tag", 64'(d_out_tag), 64'd8);
    checkOutput("bub_next_in_ready", 64'(d_in_ready), 64'd1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
    checkOutput("bub_empty", 64'(d_out_valid), 64'd0);

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 3'd5, 64'hAAAA, 64'h5555, 5'd20, 1'b1);
    applyStimulus(1'b1, 3'd6, 64'hBBBB, 64'h0, 5'd21, 1'b1);
    #2;
    d_in_valid = 1'b0;
    checkOutput("mid_valid_pre", 64'(d_out_valid), 64'd1);
    checkOutput("mid_tag_pre", 64'(d_out_tag), 64'd20);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(d_out_valid), 64'd0);
    checkOutput("mid_rst_s", d_out_s, 64'd0);
    @(negedge clk);
    #8;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 3'd0, '0, '0, 5'd0, 1'b1);
      checkOutput("mid_no_stale", 64'(d_out_valid), 64'd0);
    end

    $display("[TB] random regression");
    for (int c = 0; c < 6000 && (r_acc[0] < 1000 || r_acc[1] < 1000 || r_acc[2] < 1000); c++) begin
      @(negedge clk);
      ta = {$urandom, $urandom};
      tb = ($urandom_range(0, 7) == 0) ? ta : {$urandom, $urandom};
      r_in_valid  = ($urandom_range(0, 3) != 0);
      r_in_op     = 3'($urandom_range(0, 7));
      r_in_a      = ta;
      r_in_b      = tb;
      r_in_tag    = 5'($urandom_range(0, 31));
      r_out_ready = ($urandom_range(0, 3) != 0);
    end
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("r%0d_enough_ops", k), 64'(r_acc[k] >= 1000), 64'd1);
    @(negedge clk);
    r_in_valid  = 1'b0;
    r_out_ready = 1'b1;
    repeat (10) @(negedge clk);
    #4;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("r%0d_drained", k), 64'(r_q[k].size()), 64'd0);
      checkOutput($sformatf("r%0d_idle", k), 64'(r_out_valid[k]), 64'd0);
    end
    checkOutput("d_final_drained", 64'(d_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
